config_frame_writer: RTL and testbench
======================================

Name: config_frame_writer

Overview:
- Command-side initiator for the configuration register file. Parses an incoming byte stream from the command link into 5-byte write frames.
- Each valid frame produces exactly one single-cycle write strobe carrying an 8-bit register address and 16-bit data. These drive the register file's wr_in / wr_addr_in / data_in ports.
- Rejected frames are never written. Error status and saturating frame counters are exposed for housekeeping telemetry.

Parameters:
- HEADER, 8'hEB, frame start byte.
- MAX_ADDR, 8'd19, highest accepted register address.
- TIMEOUT_CYC, 1000, idle cycles allowed between bytes inside a frame (must be ≥2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- byte_valid_in  input  1  byte_in is valid this cycle (one-cycle qualifier, no backpressure).
- byte_in  input  8  received command byte.
- wr_out  output  1  single-cycle register write strobe.
- wr_addr_out  output  8  register address for the write.
- data_out  output  16  register data for the write.
- busy_out  output  1  frame reception in progress (state ≠ IDLE).
- err_code_out  output  2  last error: 0 none, 1 checksum, 2 address range, 3 timeout.
- frame_ok_cnt_out  output  8  count of accepted frames, saturating.
- frame_err_cnt_out  output  8  count of rejected frames, saturating.

Behaviour:
- Reset: single clock clk_in; reset rst_in is synchronous, active-high. Reset forces the FSM to IDLE and clears every output, counter and the timeout counter to 0. This applies from any state; a partial frame is discarded and no wr_out is issued.
- Frame format: HEADER, ADDR, DATA_H, DATA_L, CHK, where CHK = ADDR ^ DATA_H ^ DATA_L.
- FSM states: IDLE, GET_ADDR, GET_DH, GET_DL, GET_CHK, WRITE.
- IDLE:
  - byte_valid_in with byte_in==HEADER → GET_ADDR.
  - Any other byte is silently dropped: no error, no count.
- GET_ADDR / GET_DH / GET_DL: each accepted byte is latched into the frame shadow register and the FSM advances.
- GET_CHK, on byte_valid_in:
  - Checksum mismatch → IDLE, err_code=1, err count +1.
  - Else ADDR > MAX_ADDR → IDLE, err_code=2, err count +1.
  - Checksum takes precedence over address range.
  - Else → WRITE.
- WRITE (exactly one cycle):
  - wr_out=1; wr_addr_out/data_out are updated from the shadow register in the same cycle; ok count +1.
  - Next state is IDLE.
  - A byte_valid_in during WRITE is handled as in IDLE, i.e. a HEADER goes to GET_ADDR. Back-to-back frames are therefore never lost.
- Latency: wr_out is high in the cycle immediately after the CHK byte is sampled.
- Output hold: wr_addr_out/data_out keep the last written values between writes; they change only in WRITE.
- Timeout:
  - The counter runs only in GET_ADDR..GET_CHK and clears on every accepted byte and on entering GET_ADDR.
  - After TIMEOUT_CYC consecutive cycles with no byte_valid_in → IDLE, err_code=3, err count +1.
  - A byte arriving in the cycle the counter would expire is accepted and no timeout occurs.
- Error status: err_code_out holds the last error until a later error overwrites it or reset occurs. Successful frames do not clear it.
- Counters: 8-bit, stick at 255 with no wrap.
- busy_out is combinationally derived from state and is 1 in WRITE.

Decomposition:
- Shared package config_frame_pkg holds:
  - FSM state encoding (3-bit localparams);
  - error code constants ERR_NONE/ERR_CHK/ERR_ADDR/ERR_TMO;
  - default HEADER, MAX_ADDR and frame length (5).
- One sub-module, sat_counter8 (increment enable, sync reset, saturate at 8'hFF), is instanced twice for the ok/err counters.

Test Plan:
- Bytes EB 03 01 05 07 → one wr_out pulse the cycle after 07; wr_addr_out=8'd3, data_out=16'h0105; frame_ok_cnt_out=1; err_code_out=0.
- Bytes EB 03 01 05 00 → no wr_out; err_code_out=1; frame_err_cnt_out=1; busy_out low after CHK byte. Bytes EB 14 00 00 14 → no write; err_code_out=2.
- TIMEOUT_CYC=16: send EB 03, then 16 idle cycles → busy_out falls, err_code_out=3, no write. Repeat with next byte on idle cycle 15 → frame continues and completes normally.
- Bytes 55 AA EB 00 12 34 26 → exactly one write, addr 0, data 16'h1234; frame_err_cnt_out unchanged.
- 20 back-to-back frames, addr 0..19 data 16'h0005 with byte_valid_in every cycle:
  - 20 write pulses with matching addr/data and frame_ok_cnt_out=20.
  - The HEADER arriving during WRITE is not lost.
- rst_in asserted after EB 03 01 → no wr_out ever for that frame; all outputs 0. A following full frame writes normally. Also drive 300 bad frames → frame_err_cnt_out saturates at 255.

Source files
------------

// File: rtl/config_frame_pkg.sv
// Shared definitions for the configuration frame writer: FSM encoding,
// error codes, frame defaults and the frame checksum helper.
package config_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DH   = 3'd2,
    ST_GET_DL   = 3'd3,
    ST_GET_CHK  = 3'd4,
    ST_WRITE    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0]  DEF_HEADER   = 8'hEB;
  localparam logic [7:0]  DEF_MAX_ADDR = 8'd19;
  localparam int unsigned FRAME_LEN    = 5;

  // Frame checksum: XOR of address and both data bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] dh,
                                           input logic [7:0] dl);
    return addr ^ dh ^ dl;
  endfunction

endpackage

// File: rtl/config_frame_writer_sat_counter8.sv
// 8-bit event counter with synchronous reset that sticks at 8'hFF.
module sat_counter8 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       inc_in,
  output logic [7:0] cnt_out
);

  logic [7:0] cnt_r;

  // Count enabled events, holding once the maximum is reached.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_r <= 8'h00;
    end else if (inc_in && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'h01;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_out = cnt_r;

endmodule

// File: rtl/config_frame_writer.sv
// Parses 5-byte write frames (HEADER, ADDR, DATA_H, DATA_L, CHK) from the
// command link and issues one register write strobe per accepted frame.
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER      = DEF_HEADER,
  parameter logic [7:0]  MAX_ADDR    = DEF_MAX_ADDR,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] data_out,
  output logic        busy_out,
  output logic [1:0]  err_code_out,
  output logic [7:0]  frame_ok_cnt_out,
  output logic [7:0]  frame_err_cnt_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ZERO = TW'(0);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  state_t         state_r;
  logic [TW-1:0]  tmo_r;
  logic [7:0]     addr_r;
  logic [7:0]     dh_r;
  logic [7:0]     dl_r;
  logic           wr_r;
  logic [7:0]     wr_addr_r;
  logic [15:0]    data_r;
  logic [1:0]     err_code_r;

  logic           rx_state_s;
  logic           tmo_hit_s;
  logic           chk_bad_s;
  logic           addr_bad_s;
  logic           err_inc_s;
  logic           ok_inc_s;

  // Decode receive phase, timeout expiry and frame validity for this cycle.
  always_comb begin
    rx_state_s = (state_r == ST_GET_ADDR) || (state_r == ST_GET_DH) ||
                 (state_r == ST_GET_DL)   || (state_r == ST_GET_CHK);
    tmo_hit_s  = (tmo_r == TMO_LAST);
    chk_bad_s  = (byte_in != frame_chk(addr_r, dh_r, dl_r));
    addr_bad_s = (addr_r > MAX_ADDR);
    ok_inc_s   = (state_r == ST_WRITE);
    if (rx_state_s && !byte_valid_in && tmo_hit_s) begin
      err_inc_s = 1'b1;
    end else if ((state_r == ST_GET_CHK) && byte_valid_in && (chk_bad_s || addr_bad_s)) begin
      err_inc_s = 1'b1;
    end else begin
      err_inc_s = 1'b0;
    end
  end

  // Frame FSM with shadow registers, inter-byte timeout and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= ST_IDLE;
      tmo_r      <= TMO_ZERO;
      addr_r     <= 8'h00;
      dh_r       <= 8'h00;
      dl_r       <= 8'h00;
      wr_r       <= 1'b0;
      wr_addr_r  <= 8'h00;
      data_r     <= 16'h0000;
      err_code_r <= ERR_NONE;
    end else begin
      wr_r <= 1'b0;
      if (rx_state_s && !byte_valid_in) begin
        // No byte inside a frame: either age the timeout or abandon the frame.
        if (tmo_hit_s) begin
          state_r    <= ST_IDLE;
          tmo_r      <= TMO_ZERO;
          err_code_r <= ERR_TMO;
        end else begin
          tmo_r <= tmo_r + TMO_ONE;
        end
      end else begin
        tmo_r <= TMO_ZERO;
        case (state_r)
          ST_IDLE, ST_WRITE: begin
            if (byte_valid_in && (byte_in == HEADER)) begin
              state_r <= ST_GET_ADDR;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_GET_ADDR: begin
            addr_r  <= byte_in;
            state_r <= ST_GET_DH;
          end
          ST_GET_DH: begin
            dh_r    <= byte_in;
            state_r <= ST_GET_DL;
          end
          ST_GET_DL: begin
            dl_r    <= byte_in;
            state_r <= ST_GET_CHK;
          end
          ST_GET_CHK: begin
            if (chk_bad_s) begin
              state_r    <= ST_IDLE;
              err_code_r <= ERR_CHK;
            end else if (addr_bad_s) begin
              state_r    <= ST_IDLE;
              err_code_r <= ERR_ADDR;
            end else begin
              state_r   <= ST_WRITE;
              wr_r      <= 1'b1;
              wr_addr_r <= addr_r;
              data_r    <= {dh_r, dl_r};
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter8 u_ok_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (ok_inc_s),
    .cnt_out (frame_ok_cnt_out)
  );

  sat_counter8 u_err_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc_in  (err_inc_s),
    .cnt_out (frame_err_cnt_out)
  );

  assign wr_out       = wr_r;
  assign wr_addr_out  = wr_addr_r;
  assign data_out     = data_r;
  assign err_code_out = err_code_r;
  assign busy_out     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed testbench for config_frame_writer with a write scoreboard.
module tb_config_frame_writer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        byte_valid_in;
  logic [7:0]  byte_in;
  logic        wr_out;
  logic [7:0]  wr_addr_out;
  logic [15:0] data_out;
  logic        busy_out;
  logic [1:0]  err_code_out;
  logic [7:0]  frame_ok_cnt_out;
  logic [7:0]  frame_err_cnt_out;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;
  int wr_seen  = 0;
  int wr_base  = 0;
  logic [23:0] exp_q[$];

  config_frame_writer #(.TIMEOUT_CYC(16)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .byte_valid_in     (byte_valid_in),
    .byte_in           (byte_in),
    .wr_out            (wr_out),
    .wr_addr_out       (wr_addr_out),
    .data_out          (data_out),
    .busy_out          (busy_out),
    .err_code_out      (err_code_out),
    .frame_ok_cnt_out  (frame_ok_cnt_out),
    .frame_err_cnt_out (frame_err_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(posedge clk_in);
    #1;
    byte_valid_in = 1'b1;
    byte_in       = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      byte_valid_in = 1'b0;
      byte_in       = 8'h00;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] chk);
    put(8'hEB);
    put(a);
    put(d[15:8]);
    put(d[7:0]);
    put(chk);
  endtask

  task automatic good_frame(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
    send_frame(a, d, a ^ d[15:8] ^ d[7:0]);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk_in) begin
    if (wr_out === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_out), 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_out), 32'(e[23:16]));
        check("wr_data", 32'(data_out), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b1;
    byte_valid_in = 1'b0;
    byte_in       = 8'h00;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_wr", 32'(wr_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_err", 32'(err_code_out), 32'd0);
    check("rst_ok_cnt", 32'(frame_ok_cnt_out), 32'd0);
    check("rst_err_cnt", 32'(frame_err_cnt_out), 32'd0);
    check("rst_addr", 32'(wr_addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rst_in = 1'b0;

    // Basic frame with latency check.
    exp_q.push_back({8'h03, 16'h0105});
    send_frame(8'h03, 16'h0105, 8'h07);
    idle(1);
    @(negedge clk_in);
    check("latency_wr", 32'(wr_out), 32'd1);
    idle(3);
    check("f1_ok_cnt", 32'(frame_ok_cnt_out), 32'd1);
    check("f1_err", 32'(err_code_out), 32'd0);
    check("f1_busy", 32'(busy_out), 32'd0);

    // Checksum error.
    send_frame(8'h03, 16'h0105, 8'h00);
    idle(1);
    check("chk_busy", 32'(busy_out), 32'd0);
    idle(2);
    check("chk_err", 32'(err_code_out), 32'd1);
    check("chk_err_cnt", 32'(frame_err_cnt_out), 32'd1);

    // Address out of range with valid checksum.
    send_frame(8'h14, 16'h0000, 8'h14);
    idle(3);
    check("addr_err", 32'(err_code_out), 32'd2);
    check("addr_err_cnt", 32'(frame_err_cnt_out), 32'd2);

    // Timeout: 15 idle cycles keep the frame, the 16th abandons it.
    put(8'hEB);
    put(8'h03);
    idle(16);
    check("tmo_busy_pre", 32'(busy_out), 32'd1);
    idle(1);
    check("tmo_busy_post", 32'(busy_out), 32'd0);
    check("tmo_err", 32'(err_code_out), 32'd3);
    check("tmo_err_cnt", 32'(frame_err_cnt_out), 32'd3);

    // Byte arriving on the expiry cycle is accepted.
    exp_q.push_back({8'h03, 16'h0105});
    put(8'hEB);
    put(8'h03);
    idle(15);
    put(8'h01);
    put(8'h05);
    idle(15);
    put(8'h07);
    idle(3);
    check("tmo_edge_ok_cnt", 32'(frame_ok_cnt_out), 32'd2);
    check("tmo_edge_err_cnt", 32'(frame_err_cnt_out), 32'd3);

    // Garbage before header is dropped silently; success keeps last error.
    exp_q.push_back({8'h00, 16'h1234});
    put(8'h55);
    put(8'hAA);
    send_frame(8'h00, 16'h1234, 8'h26);
    idle(3);
    check("garb_ok_cnt", 32'(frame_ok_cnt_out), 32'd3);
    check("garb_err_cnt", 32'(frame_err_cnt_out), 32'd3);
    check("garb_err_hold", 32'(err_code_out), 32'd3);
    check("garb_addr_hold", 32'(wr_addr_out), 32'd0);
    check("garb_data_hold", 32'(data_out), 32'h1234);

    // 20 back-to-back frames.
    wr_base = wr_seen;
    for (int i = 0; i < 20; i++) begin
      good_frame(8'(i), 16'h0005);
    end
    idle(3);
    check("b2b_writes", 32'(wr_seen - wr_base), 32'd20);
    check("b2b_ok_cnt", 32'(frame_ok_cnt_out), 32'd23);
    check("b2b_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame.
    wr_base = wr_seen;
    put(8'hEB);
    put(8'h03);
    put(8'h01);
    @(posedge clk_in);
    #1;
    rst_in        = 1'b1;
    byte_valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("mid_rst_busy", 32'(busy_out), 32'd0);
    check("mid_rst_err", 32'(err_code_out), 32'd0);
    check("mid_rst_ok_cnt", 32'(frame_ok_cnt_out), 32'd0);
    check("mid_rst_err_cnt", 32'(frame_err_cnt_out), 32'd0);
    check("mid_rst_addr", 32'(wr_addr_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    rst_in = 1'b0;
    put(8'h05);
    put(8'h07);
    idle(3);
    check("mid_rst_no_wr", 32'(wr_seen - wr_base), 32'd0);
    good_frame(8'h05, 16'hABCD);
    idle(3);
    check("post_rst_ok_cnt", 32'(frame_ok_cnt_out), 32'd1);
    check("post_rst_writes", 32'(wr_seen - wr_base), 32'd1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h03, 16'h0105, 8'h00);
    end
    idle(3);
    check("sat_err_cnt", 32'(frame_err_cnt_out), 32'd255);
    check("sat_err_code", 32'(err_code_out), 32'd1);
    check("sat_ok_cnt", 32'(frame_ok_cnt_out), 32'd1);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
